// File: rtl/fifo_w8_r1_pkg.sv
// -----------------------------------------------------------------------------
// fifo_w8_r1_pkg
// Shared constants and helpers for the 8-bit-in / 1-bit-out width-converting
// FIFO (fifo_w8_r1_sync) and its storage array (fifo_w8_r1_mem).
//   RATIO / RATIO_LOG2 : bits per stored byte and its log2
//   clog2()            : elaboration-time ceil(log2) for address widths
//   byte_occupancy()   : byte slots in use, from the write byte pointer and
//                        the byte part of the read bit pointer
// -----------------------------------------------------------------------------
package fifo_w8_r1_pkg;

  localparam int RATIO      = 8;
  localparam int RATIO_LOG2 = 3;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Pointers carry one wrap bit above the address, so the difference is taken
  // modulo 2^(addr_w+1). A partially read byte still counts as occupied
  // because rd_byte only advances once its last bit has been read.
  function automatic logic [31:0] byte_occupancy(input logic [31:0] wr_ptr,
                                                 input logic [31:0] rd_byte,
                                                 input int unsigned addr_w);
    logic [31:0] mask;
    mask = (32'd1 << (addr_w + 1)) - 32'd1;
    return (wr_ptr - rd_byte) & mask;
  endfunction

endpackage

// File: rtl/fifo_w8_r1_mem.sv
// -----------------------------------------------------------------------------
// fifo_w8_r1_mem
// DEPTH x 8 storage for fifo_w8_r1_sync. Synchronous write, asynchronous read
// so the top level can select a bit and register it in the same cycle.
// Contents are never reset.
//   clk     : write clock
//   wr_en   : write strobe (already qualified by the top level)
//   wr_addr : byte address to write
//   din     : byte to write
//   rd_addr : byte address to read
//   rd_data : byte at rd_addr (combinational)
// -----------------------------------------------------------------------------
module fifo_w8_r1_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        din,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= din;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_w8_r1_sync.sv
// -----------------------------------------------------------------------------
// fifo_w8_r1_sync
// Single-clock width-converting FIFO: bytes are pushed in, bits are popped
// out one per accepted read, most significant bit of each byte first.
// Optional build macro: FIFO_W8_R1_COUNT_EN adds the data_count output
// (number of unread bits, 0..DEPTH*8).
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   din        : write byte
//   wr_en      : write request
//   rd_en      : read request, one bit per accepted read
//   dout       : read bit, registered, valid right after the accepting edge
//   full       : no free byte slot
//   empty      : no unread bit
//   data_count : unread bits (only with FIFO_W8_R1_COUNT_EN)
//
// Handshake: a write is accepted on a rising edge where wr_en && !full, a read
// is accepted on a rising edge where rd_en && !empty. Requests presented while
// the matching flag is set are dropped without side effects. Flags come from
// the current pointers only, so both requests of one cycle are judged against
// the flags seen before the edge.
// -----------------------------------------------------------------------------
module fifo_w8_r1_sync
  import fifo_w8_r1_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       wr_en,
  input  logic       rd_en,
  output logic       dout,
  output logic       full,
  output logic       empty
`ifdef FIFO_W8_R1_COUNT_EN
  ,
  output logic [ADDR_W+3:0] data_count
`endif
);

  // Byte pointer for writes, bit pointer for reads; both have a wrap bit.
  logic [ADDR_W:0]            wr_ptr;
  logic [ADDR_W+RATIO_LOG2:0] rd_ptr;
  logic [ADDR_W:0]            rd_byte;
  logic [RATIO_LOG2-1:0]      rd_bit;
  logic [ADDR_W+RATIO_LOG2:0] wr_bits;
  logic [7:0]                 rd_data;
  logic                       wr_accept;
  logic                       rd_accept;

  assign rd_byte = rd_ptr[ADDR_W+RATIO_LOG2:RATIO_LOG2];
  assign rd_bit  = rd_ptr[RATIO_LOG2-1:0];
  assign wr_bits = {wr_ptr, {RATIO_LOG2{1'b0}}};

  assign empty = (wr_bits == rd_ptr);
  assign full  = (byte_occupancy(32'(wr_ptr), 32'(rd_byte), ADDR_W) == 32'(DEPTH));

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  fifo_w8_r1_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .din     (din),
    .rd_addr (rd_byte[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (wr_accept) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // MSB first: bit offset k within the byte selects bit 7-k, which for a
  // 3-bit offset is simply its bitwise inverse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      dout   <= 1'b0;
    end else if (rd_accept) begin
      rd_ptr <= rd_ptr + 1'b1;
      dout   <= rd_data[~rd_bit];
    end
  end

`ifdef FIFO_W8_R1_COUNT_EN
  // Difference never exceeds DEPTH*8, so modulo arithmetic is exact.
  assign data_count = wr_bits - rd_ptr;
`else
  // No occupancy counter in this build.
`endif

endmodule

// File: tb/tb_fifo_w8_r1_sync.sv
// -----------------------------------------------------------------------------
// tb_fifo_w8_r1_sync
// Self-checking bench for fifo_w8_r1_sync. The reference is a queue of unread
// bits: writes append 8 bits MSB first, reads pop the front. Byte slots in use
// are ceil(bits/8). Build with FIFO_W8_R1_COUNT_EN to also check data_count.
// -----------------------------------------------------------------------------
module tb_fifo_w8_r1_sync;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       wr_en;
  logic       rd_en;
  logic       dout;
  logic       full;
  logic       empty;
`ifdef FIFO_W8_R1_COUNT_EN
  logic [ADDR_W+3:0] data_count;
`endif

  fifo_w8_r1_sync #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .dout  (dout),
    .full  (full),
    .empty (empty)
`ifdef FIFO_W8_R1_COUNT_EN
    ,
    .data_count (data_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];
  logic       exp_dout;
  int         n_checks;
  int         n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_bytes();
    return (exp_q.size() + 7) / 8;
  endfunction

  function automatic logic model_full();
    return model_bytes() == DEPTH;
  endfunction

  function automatic logic model_empty();
    return exp_q.size() == 0;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".dout"},  32'(dout),  32'(exp_dout));
    check({tag, ".full"},  32'(full),  32'(model_full()));
    check({tag, ".empty"}, 32'(empty), 32'(model_empty()));
`ifdef FIFO_W8_R1_COUNT_EN
    check({tag, ".count"}, 32'(data_count), 32'(exp_q.size()));
`endif
  endtask

  // ---------------- drivers ----------------
  // Called away from the edge; drives inputs, lets one edge pass, updates the
  // model from the pre-edge view, then compares.
  task automatic do_cycle(input string tag, input logic wr, input logic [7:0] d, input logic rd);
    logic wr_ok;
    logic rd_ok;
    wr_en = wr;
    din   = d;
    rd_en = rd;
    wr_ok = wr && !model_full();
    rd_ok = rd && !model_empty();
    @(posedge clk);
    #1;
    if (rd_ok) exp_dout = exp_q.pop_front();
    if (wr_ok) begin
      for (int b = 7; b >= 0; b--) exp_q.push_back(d[b]);
    end
    check_outputs(tag);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic write_byte(input string tag, input logic [7:0] d);
    do_cycle(tag, 1'b1, d, 1'b0);
  endtask

  task automatic read_bit(input string tag);
    do_cycle(tag, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 1000) begin
      read_bit(tag);
      guard++;
    end
    check({tag, ".drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int written;
    int cyc;
    logic w;
    logic r;
    n_checks = 0;
    n_pass   = 0;
    exp_dout = 1'b0;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    din      = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    #3;
    rst_n = 1'b1;

    // 1: single byte, read out bit by bit, then one extra read while empty
    write_byte("t1.wr", 8'hA5);
    for (int i = 0; i < 9; i++) read_bit("t1.rd");
    check("t1.dout_hold", 32'(dout), 32'd1);
    check("t1.empty",     32'(empty), 32'd1);

    // 2: fill to full, overflow write dropped, drain in order
    for (int i = 0; i < 16; i++) write_byte("t2.wr", 8'(i));
    check("t2.full", 32'(full), 32'd1);
    write_byte("t2.ovf", 8'hFF);
    drain("t2.rd");

    // 3: full, partial byte keeps slot; write racing the freeing read is rejected
    for (int i = 0; i < 16; i++) write_byte("t3.wr", 8'($urandom_range(0, 255)));
    for (int i = 0; i < 7; i++) read_bit("t3.rd7");
    check("t3.full_after7", 32'(full), 32'd1);
    do_cycle("t3.rd8_wr", 1'b1, 8'h3C, 1'b1);
    check("t3.full_after8", 32'(full), 32'd0);
    write_byte("t3.wr_retry", 8'h3C);
    check("t3.full_again", 32'(full), 32'd1);
    drain("t3.rd");
    check("t3.last_bit", 32'(dout), 32'd0);

    // 4: simultaneous write/read on empty: read ignored
    do_cycle("t4.wr_rd", 1'b1, 8'h80, 1'b1);
    check("t4.dout_hold", 32'(dout), 32'd0);
    read_bit("t4.rd");
    check("t4.dout_msb", 32'(dout), 32'd1);
    drain("t4.rd");

    // 5: 40 random bytes with random reads; occupancy kept below DEPTH
    written = 0;
    cyc     = 0;
    while (written < 40 && cyc < 4000) begin
      w = (model_bytes() < DEPTH - 1) && ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 3) != 0);
      do_cycle("t5", w, 8'($urandom_range(0, 255)), r);
      if (w) written++;
      cyc++;
    end
    check("t5.written", 32'(written), 32'd40);
    drain("t5.rd");

    // 6: asynchronous reset mid-cycle with data in flight
    for (int i = 0; i < 3; i++) write_byte("t6.wr", 8'hFF);
    for (int i = 0; i < 5; i++) read_bit("t6.rd");
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_dout = 1'b0;
    check_outputs("t6.async_rst");
    #2;
    rst_n = 1'b1;
    write_byte("t6.wr01", 8'h01);
    for (int i = 0; i < 7; i++) read_bit("t6.rd01");
    check("t6.bit6", 32'(dout), 32'd0);
    read_bit("t6.rd01");
    check("t6.bit7", 32'(dout), 32'd1);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
